// File: rtl/instr_encoder.sv
// Encodes field-level instruction descriptors into 32-bit MIPS words and
// writes them sequentially into instruction memory over an ack-based port.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_ack,
  output logic [8:0]        word_count,
  output logic              busy,
  output logic              done,
  output logic              err_kind,
  output logic              err_full
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

  localparam logic [8:0]        MAXW = 9'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              fin_q, fin_d;
  logic              ek_q, ek_d;
  logic              ef_q, ef_d;

  logic [5:0]  op;
  logic        enc_ok;
  logic [31:0] enc_word;
  logic        full, hs;

  always_comb begin
    op     = 6'h00;
    enc_ok = 1'b1;
    case (in_kind)
      5'd0:    op = 6'h00;
      5'd1:    op = 6'h08;
      5'd2:    op = 6'h09;
      5'd3:    op = 6'h0C;
      5'd4:    op = 6'h0D;
      5'd5:    op = 6'h0A;
      5'd6:    op = 6'h0B;
      5'd7:    op = 6'h23;
      5'd8:    op = 6'h25;
      5'd9:    op = 6'h24;
      5'd10:   op = 6'h2B;
      5'd11:   op = 6'h29;
      5'd12:   op = 6'h28;
      5'd13:   op = 6'h04;
      5'd14:   op = 6'h05;
      5'd15:   op = 6'h02;
      5'd16:   op = 6'h03;
      default: enc_ok = 1'b0;
    endcase
    if (in_kind == 5'd0)
      enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
    else if (in_kind >= 5'd15)
      enc_word = {op, in_target};
    else
      enc_word = {op, in_rs, in_rt, in_imm};
  end

  assign full = (cnt_q >= MAXW);
  assign hs   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    ek_d    = ek_q;
    ef_d    = ef_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
          cnt_d   = '0;
          ek_d    = 1'b0;
          ef_d    = 1'b0;
          fin_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs && enc_ok) begin
          data_d  = enc_word;
          fin_d   = finish;
          state_d = WRITE;
        end else begin
          // A rejected kind consumes the descriptor but produces no write.
          if (hs) ek_d = 1'b1;
          if (in_valid && full) ef_d = 1'b1;
          if (finish) state_d = DONE;
        end
      end
      WRITE: begin
        if (finish) fin_d = 1'b1;
        if (mem_ack) begin
          addr_d  = addr_q + STEP;
          cnt_d   = cnt_q + 9'd1;
          fin_d   = 1'b0;
          state_d = (fin_q || finish) ? DONE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      ek_q    <= 1'b0;
      ef_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      ek_q    <= ek_d;
      ef_q    <= ef_d;
    end
  end

  assign in_ready   = (state_q == RUN) && !full;
  assign mem_write  = (state_q == WRITE);
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign word_count = cnt_q;
  assign busy       = (state_q == RUN) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign err_kind   = ek_q;
  assign err_full   = ef_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vector table, hand-written corner sequences,
// and randomized descriptors checked against a field-level encoding model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0, mem_ack = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [4:0]  in_kind = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  logic        in_ready, mem_write, busy, done, err_kind, err_full;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [8:0]  word_count;

  logic        s_in_ready, s_mem_write, s_busy, s_done, s_err_kind, s_err_full;
  logic [9:0]  s_mem_addr;
  logic [31:0] s_mem_data;
  logic [8:0]  s_word_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .MAX_WORDS(256)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .word_count(word_count), .busy(busy), .done(done), .err_kind(err_kind),
    .err_full(err_full));

  instr_encoder #(.ADDR_W(10), .MAX_WORDS(2)) u_small (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_kind(in_kind), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .mem_write(s_mem_write),
    .mem_addr(s_mem_addr), .mem_data(s_mem_data), .mem_ack(mem_ack),
    .word_count(s_word_count), .busy(s_busy), .done(s_done), .err_kind(s_err_kind),
    .err_full(s_err_full));

  // Which instance the handshake/write helpers observe.
  logic        sel = 1'b0;
  logic        v_rdy, v_mw;
  logic [9:0]  v_addr;
  logic [31:0] v_data;
  logic [8:0]  v_cnt;
  assign v_rdy  = sel ? s_in_ready   : in_ready;
  assign v_mw   = sel ? s_mem_write  : mem_write;
  assign v_addr = sel ? s_mem_addr   : mem_addr;
  assign v_data = sel ? s_mem_data   : mem_data;
  assign v_cnt  = sel ? s_word_count : word_count;

  typedef struct {
    logic [4:0]  kind, rs, rt, rd, sh;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
    int          dly;
  } vec_t;

  int   n_chk = 0, n_fail = 0;
  logic ack_tied = 1'b0;

  logic [5:0] OPC [17] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B, 6'h23,
                           6'h25, 6'h24, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03};

  function automatic logic [31:0] model_enc(input vec_t v);
    int k = int'(v.kind);
    if (k == 0)  return {6'b0, v.rs, v.rt, v.rd, v.sh, v.funct};
    if (k <= 14) return {OPC[k], v.rs, v.rt, v.imm};
    return {OPC[k], v.tgt};
  endfunction

  function automatic vec_t mk(input int kind, rs, rt, rd, sh, funct, imm, tgt,
                              input logic [31:0] exp, input int dly);
    vec_t v;
    v.kind = 5'(kind); v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.sh = 5'(sh);
    v.funct = 6'(funct); v.imm = 16'(imm); v.tgt = 26'(tgt); v.exp = exp; v.dly = dly;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [9:0] b);
    base_addr = b; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1; tick(); finish = 1'b0;
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    in_kind = v.kind; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_shamt = v.sh;
    in_funct = v.funct; in_imm = v.imm; in_target = v.tgt; in_valid = 1'b1;
    while (!v_rdy && n < 50) begin tick(); n++; end
    chk("in_ready_wait", 32'(v_rdy), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_write(input string nm, input logic [9:0] ea,
                            input logic [31:0] ed, input int dly);
    int n = 0;
    while (!v_mw && n < 20) begin tick(); n++; end
    chk({nm, "_mem_write"}, 32'(v_mw), 32'd1);
    chk({nm, "_addr"}, 32'(v_addr), 32'(ea));
    chk({nm, "_data"}, v_data, ed);
    for (int d = 0; d < dly; d++) begin
      tick();
      chk({nm, "_hold_write"}, 32'(v_mw), 32'd1);
      chk({nm, "_hold_addr"}, 32'(v_addr), 32'(ea));
      chk({nm, "_hold_data"}, v_data, ed);
      chk({nm, "_hold_ready"}, 32'(v_rdy), 32'd0);
    end
    mem_ack = 1'b1; tick(); mem_ack = ack_tied;
    chk({nm, "_write_drop"}, 32'(v_mw), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, "_mem_data"}, mem_data, 32'd0);
    chk({nm, "_word_count"}, 32'(word_count), 32'd0);
    chk({nm, "_flags"}, 32'({in_ready, busy, done, err_kind, err_full}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    vec_t rv;
    logic [9:0] rbase;
    int nw;

    tbl[0] = mk(0, 1, 2, 3, 0, 'h20, 'h0, 'h0, 32'h00221820, 0);
    tbl[1] = mk(7, 29, 8, 31, 0, 'h3F, 'h4, 'h0, 32'h8FA80004, 0);
    tbl[2] = mk(13, 1, 2, 0, 0, 0, 'hFFFF, 'h0, 32'h1022FFFF, 0);
    tbl[3] = mk(15, 7, 9, 0, 0, 0, 'h1234, 'h10, 32'h08000010, 3);
    tbl[4] = mk(16, 0, 0, 0, 0, 0, 0, 'h10, 32'h0C000010, 3);
    tbl[5] = mk(12, 3, 5, 0, 0, 0, 'h1234, 'h0, 32'hA0651234, 1);
    tbl[6] = mk(4, 0, 4, 0, 0, 0, 'h00FF, 'h0, 32'h340400FF, 0);

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    nrst = 1'b1;
    tick();

    // ADDI with mem_ack tied high
    ack_tied = 1'b1; mem_ack = 1'b1;
    do_start(10'h040);
    chk("run_busy", 32'(busy), 32'd1);
    send(mk(1, 1, 2, 0, 0, 0, 'h5, 0, 32'h20220005, 0));
    wait_write("addi", 10'h040, 32'h20220005, 0);
    chk("addi_count", 32'(word_count), 32'd1);
    ack_tied = 1'b0; mem_ack = 1'b0;
    do_finish();
    chk("addi_done", 32'(done), 32'd1);

    // Table session from address 0, then an unsupported kind and ORI
    do_start(10'h000);
    for (int i = 0; i < 6; i++) begin
      send(tbl[i]);
      wait_write($sformatf("tbl%0d", i), 10'(4 * i), tbl[i].exp, tbl[i].dly);
      chk($sformatf("tbl%0d_count", i), 32'(word_count), 32'(i + 1));
    end
    send(mk(20, 1, 1, 1, 1, 1, 1, 1, 32'h0, 0));
    chk("badkind_nowrite", 32'(mem_write), 32'd0);
    chk("badkind_err", 32'(err_kind), 32'd1);
    chk("badkind_count", 32'(word_count), 32'd6);
    send(tbl[6]);
    wait_write("ori", 10'h018, tbl[6].exp, 0);
    chk("ori_err_sticky", 32'(err_kind), 32'd1);
    do_finish();

    // Randomized descriptors against the model; base exercises wrap and low bits
    rbase = 10'h3F3;
    do_start(rbase);
    chk("restart_err_clear", 32'(err_kind), 32'd0);
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      rv.kind = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31))
                                             : 5'($urandom_range(0, 16));
      rv.rs = 5'($urandom); rv.rt = 5'($urandom); rv.rd = 5'($urandom);
      rv.sh = 5'($urandom); rv.funct = 6'($urandom); rv.imm = 16'($urandom);
      rv.tgt = 26'($urandom);
      send(rv);
      if (rv.kind > 5'd16) begin
        chk("rnd_bad_nowrite", 32'(mem_write), 32'd0);
        chk("rnd_bad_err", 32'(err_kind), 32'd1);
      end else begin
        wait_write($sformatf("rnd%0d", i), 10'(((int'(rbase) & ~3) + 4 * nw) % 1024),
                   model_enc(rv), int'($urandom_range(0, 2)));
        nw++;
      end
      chk("rnd_count", 32'(word_count), 32'(nw));
    end
    do_finish();

    // Capacity limit on the MAX_WORDS=2 instance
    sel = 1'b1;
    do_start(10'h000);
    send(tbl[0]); wait_write("full0", 10'h000, tbl[0].exp, 0);
    send(tbl[1]); wait_write("full1", 10'h004, tbl[1].exp, 0);
    chk("full_ready_low", 32'(s_in_ready), 32'd0);
    chk("full_err_before", 32'(s_err_full), 32'd0);
    in_kind = tbl[2].kind; in_rs = tbl[2].rs; in_rt = tbl[2].rt; in_imm = tbl[2].imm;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    chk("full_err", 32'(s_err_full), 32'd1);
    chk("full_nowrite", 32'(s_mem_write), 32'd0);
    chk("full_count", 32'(s_word_count), 32'd2);
    do_finish();
    chk("full_done", 32'(s_done), 32'd1);
    sel = 1'b0;
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;

    // Asynchronous reset in the middle of a write
    do_start(10'h080);
    send(tbl[0]);
    chk("rst_in_write", 32'(mem_write), 32'd1);
    #2 nrst = 1'b0;
    #1 chk_all_zero("async_rst");
    tick(); nrst = 1'b1; tick();
    chk("post_rst_idle", 32'({busy, done, in_ready}), 32'd0);
    do_start(10'h100);
    send(mk(1, 1, 2, 0, 0, 0, 'h5, 0, 32'h0, 0));
    wait_write("post_rst", 10'h100, 32'h20220005, 0);
    chk("post_rst_count", 32'(word_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Producer end of the opcode interface that the core control unit decodes.
- Accepts field-level instruction descriptors over a valid/ready handshake and encodes each into a 32-bit MIPS word.
- Writes encoded words sequentially into instruction memory through an ack-based write port.
- Used by the bench and boot path to load programs before the core is released from reset.

Parameters:
- ADDR_W, 10, byte-address width of the instruction memory port.
- MAX_WORDS, 256, capacity in words; writes beyond this are refused.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse: arm a load session.
- base_addr  in  ADDR_W  first byte address; sampled on start; bits [1:0] forced to 0.
- finish  in  1  1-cycle pulse: end the session once no write is pending.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid & in_ready.
- in_kind  in  5  instruction select: 0 R-type, 1 ADDI, 2 ADDIU, 3 ANDI, 4 ORI, 5 SLTI, 6 SLTIU, 7 LW, 8 LHU, 9 LBU, 10 SW, 11 SH, 12 SB, 13 BEQ, 14 BNE, 15 J, 16 JAL.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type target.
- mem_write  out  1  write request, held until mem_ack.
- mem_addr  out  ADDR_W  write byte address.
- mem_data  out  32  encoded word.
- mem_ack  in  1  memory accepted the write this cycle.
- word_count  out  9  words written this session.
- busy  out  1  high in RUN and WRITE.
- done  out  1  high in DONE.
- err_kind  out  1  sticky: unsupported in_kind (>16) was accepted.
- err_full  out  1  sticky: descriptor offered while word_count == MAX_WORDS.

Behaviour:
- Reset (nrst low, asynchronous, any state):
  - state IDLE.
  - All outputs 0, including mem_addr, mem_data and word_count.
  - An in-flight write is dropped; a reset in mid-session leaves memory contents undefined.
- FSM states: IDLE, RUN, WRITE, DONE.
  - IDLE: in_ready=0. On start: addr<=base_addr, word_count<=0, clear err_kind and err_full, go to RUN.
  - RUN: in_ready=1 while word_count<MAX_WORDS.
    - On handshake with a valid kind: latch the encoded word into mem_data, set mem_write=1, go to WRITE. mem_write asserts the cycle after the handshake.
    - On handshake with kind>16: set err_kind, write nothing, stay in RUN.
    - If word_count==MAX_WORDS: in_ready=0. An in_valid seen in this condition sets err_full.
    - On finish (with no handshake in the same cycle): go to DONE.
  - WRITE: in_ready=0; mem_write, mem_addr and mem_data held stable.
    - On mem_ack: mem_write<=0, addr<=addr+4 (wraps modulo 2^ADDR_W), word_count+1, go to RUN.
    - A finish seen during WRITE is remembered; after the ack the FSM goes to DONE instead of RUN.
  - DONE: in_ready=0, done=1. On start: behaves as start from IDLE (re-arm). Otherwise stays in DONE.
- Simultaneous events:
  - Handshake and finish in the same RUN cycle: the handshake wins, the word is written, then the FSM goes to DONE.
  - start outside IDLE or DONE is ignored.
- Encoding:
  - Kind 0 (R-type): {6'b000000, rs, rt, rd, shamt, funct}.
  - Kinds 1–14 (I-type): {op, rs, rt, imm}.
  - Kinds 15–16 (J-type): {op, target}.
  - Opcode values: ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, SLTI 001010, SLTIU 001011, LW 100011, LHU 100101, LBU 100100, SW 101011, SH 101001, SB 101000, BEQ 000100, BNE 000101, J 000010, JAL 000011.
  - Unused fields are ignored.
- Throughput: at most one word per 2 cycles with mem_ack tied high.

Test Plan:
- Start with base_addr=0x040, then ADDI (rs=1, rt=2, imm=0x0005) with mem_ack tied 1 -> mem_write for 1 cycle, addr 0x040, data 0x20220005, word_count=1.
- R-type (rs=1, rt=2, rd=3, shamt=0, funct=0x20), then LW (rs=29, rt=8, imm=4), then BEQ (rs=1, rt=2, imm=0xFFFF) -> data 0x00221820, 0x8FA80004, 0x1022FFFF at addresses 0x0, 0x4, 0x8.
- J with target 0x10 and JAL with target 0x10, mem_ack delayed 3 cycles -> data 0x08000010, then 0x0C000010; mem_write, mem_addr and mem_data stable until ack; in_ready=0 during WRITE.
- in_kind=20 offered -> err_kind=1, no mem_write, word_count unchanged. Then ORI (rs=0, rt=4, imm=0x00FF) -> data 0x340400FF, err_kind stays 1.
- MAX_WORDS=2: three descriptors offered -> two writes, in_ready=0 afterward, err_full=1. Then finish -> done=1.
- Assert nrst low while in WRITE -> mem_write=0 and all outputs 0 immediately (asynchronously); FSM in IDLE after release; a new start works normally.
